alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the single-cycle datapath ALU. Width is set by a parameter, and the flags and result are held in registers.
- Bitwise, add/sub and immediate ops take one cycle. Shifts iterate one bit per cycle, and MUL is an iterative shift-add unit.
- Carry-in for ADC/SUC comes from the internal registered C flag.
- Sits between the register-file read ports and the writeback mux. The control FSM drives it through a Start/Done handshake.

Parameters:
- WIDTH, 16, datapath width in bits (>= 8, even).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from Op2[SHW-1:0].

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request. Accepted only when Ready=1.
- OpCode  input  alu_pkg::AluOp_t  operation. Sampled with Start.
- Op1  input  WIDTH  operand A. Sampled with Start.
- Op2  input  WIDTH  operand B. Sampled with Start.
- Ready  output  1  high in IDLE. Low while an iterative op runs.
- Done  output  1  one-cycle pulse. Result and Flags are valid from this cycle.
- Result  output  WIDTH  registered result. Holds until the next completion.
- Flags  output  4  registered {Z,N,C,V}. Bit positions come from alu_pkg.

Behaviour:
- Reset: state IDLE, Result=0, Flags=0, Done=0, Ready=1. Reset mid-operation abandons the op and produces no Done.
- FSM states are IDLE, SHIFT and MUL.
- Single-cycle ops: Start accepted in cycle 0 -> Result and Flags registered at the edge -> Done=1 in cycle 1. State stays IDLE, so back-to-back Starts give one op per cycle.
- Shift (LSL/LSR/ASR), n = Op2[SHW-1:0]:
  - n=0: behaves as a single-cycle op. Result=Op1, C preserved.
  - n>=1: IDLE -> SHIFT with the counter loaded to n. One bit is shifted per cycle. Done occurs in cycle n+1, then the FSM returns to IDLE.
- MUL: IDLE -> MUL for WIDTH iterations. Done occurs in cycle WIDTH+1.
  - Result = low WIDTH bits of the unsigned product.
  - C = 1 if any high product bit is nonzero. V is preserved.
- Start while Ready=0 is ignored; no queueing.
- Arithmetic is performed at WIDTH+1 bits.
  - ADD: A+B. ADC: A+B+C.
  - SUB: A+~B+1. SUC: A+~B+C.
  - CMP: as SUB, but Result is unchanged and Done still pulses.
  - NEG: 0-A.
  - C = bit WIDTH of the sum. For subtraction, C means "no borrow".
  - V (add): operands have the same sign and the result sign differs.
  - V (sub/NEG): operands have different signs and the result sign differs from A.
- Logic ops (AND, OR, XOR, NOT, NAND, NOR): update Z and N; C and V preserved.
- Shift flags: Z and N updated. C = last bit shifted out. V preserved.
- LUI: Result = {Op2[WIDTH/2-1:0], Op1[WIDTH/2-1:0]}. Flags unchanged.
- LLI: Result = {Op1[WIDTH-1:WIDTH/2], Op2[WIDTH/2-1:0]}. Flags unchanged.
- Z = (result==0) and N = result MSB, both evaluated on the final value. For CMP they are evaluated on the difference.
- Flags change only in the Done cycle. Intermediate shift/MUL values are never visible on Result.
- Undefined OpCode: acts as a single-cycle op with Result and Flags unchanged; Done still pulses.

Decomposition:
- alu_pkg holds:
  - enum AluOp_t: ADD, ADC, SUB, SUC, CMP, NEG, AND, OR, XOR, NOT, NAND, NOR, LSL, LSR, ASR, LUI, LLI, MUL.
  - enum AluState_t: IDLE, SHIFT, MUL.
  - localparams FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - A function is_iterative(op).
- One natural sub-module, alu_iter_unit: the shared shift/multiply datapath with counter, accumulator and busy/last outputs. alu_seq keeps the FSM, the combinational single-cycle path, and the flag/result registers.

Test Plan (WIDTH=16):
- Reset asserted mid-MUL, then released -> Result=0, Flags=0, Ready=1, no Done. A following ADD 1+1 -> Done in cycle 1, Result=0x0002.
- ADD 0x7FFF+0x0001 -> Done in cycle 1, Result=0x8000, Z=0, N=1, C=0, V=1. Then SUB 0x0005-0x0005 -> Result=0, Z=1, C=1, V=0.
- ADD 0xFFFF+0x0001 (sets C=1), then ADC 0x0000+0x0000 -> Result=0x0001, C=0. Then AND 0xF0F0&0x0F0F -> Result=0, Z=1, C and V preserved.
- LSR 0x8001 by 4 -> Ready low for cycles 1-4, Done in cycle 5, Result=0x0800, C=0. ASR 0x8000 by 15 -> Result=0xFFFF, N=1, Done in cycle 16.
- MUL 300*300 -> Done in cycle 17, Result=0x5F90, C=1. A Start pulsed in cycle 3 with ADD is ignored: Result after Done is still 0x5F90.
- LUI Op1=0x1234, Op2=0x00AB -> Result=0xAB34, Flags unchanged. CMP 3,5 -> Result unchanged, N=1, C=0, Done pulses.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flag bit positions
// and opcode classification helpers.
package alu_pkg;

    localparam int unsigned OP_W    = 5;
    localparam int unsigned FLAGS_W = 4;

    // Flag register layout {Z,N,C,V}
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD, OP_ADC, OP_SUB, OP_SUC, OP_CMP, OP_NEG,
        OP_AND, OP_OR,  OP_XOR, OP_NOT, OP_NAND, OP_NOR,
        OP_LSL, OP_LSR, OP_ASR, OP_LUI, OP_LLI, OP_MUL
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL
    } alu_state_t;

    // Ops that run on the shared shift/multiply datapath
    function automatic logic is_iterative(input alu_op_t op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Start/Done request bus between the control FSM (master) and the ALU (slave).
//   start/opcode/op1/op2 : request, sampled when start && ready
//   ready                : ALU can accept a request this cycle
//   done                 : one-cycle completion pulse, result/flags valid from then
//   result/flags         : registered outputs, hold until the next completion
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);
    logic                 start;
    alu_op_t              opcode;
    logic [WIDTH-1:0]     op1;
    logic [WIDTH-1:0]     op2;
    logic                 ready;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic [FLAGS_W-1:0]   flags;

    modport master (
        output start, opcode, op1, op2,
        input  ready, done, result, flags
    );

    modport slave (
        input  start, opcode, op1, op2,
        output ready, done, result, flags
    );
endinterface

// File: rtl/alu_iter_unit.sv
// Shared iterative datapath: one-bit-per-cycle shifter and shift-add multiplier.
//   load    : capture op/operands and start iterating (counter = n or WIDTH)
//   busy    : iteration in progress
//   last    : current step is the final one
//   res_c   : value after the current step (final value when last)
//   carry_c : shift: bit shifted out this step; mul: high product half nonzero
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] res_c,
    output logic             carry_c
);

    localparam int unsigned CW  = SHW + 1;
    localparam int unsigned MSB = WIDTH - 1;

    alu_op_t          op_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_ld;
    logic [WIDTH-1:0] lo_q, lo_n;
    logic [WIDTH-1:0] hi_q, hi_n;
    logic [WIDTH-1:0] mc_q;
    logic [WIDTH:0]   madd;

    assign cnt_ld = (op == OP_MUL) ? CW'(WIDTH) : CW'(b[SHW-1:0]);

    // Iteration state; for MUL {hi,lo} is the product/multiplier pair
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q  <= OP_ADD;
            cnt_q <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            mc_q  <= '0;
            busy  <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            op_q  <= op;
            cnt_q <= cnt_ld;
            lo_q  <= (op == OP_MUL) ? b : a;
            hi_q  <= '0;
            mc_q  <= a;
            busy  <= 1'b1;
            last  <= (cnt_ld == CW'(1));
        end else if (busy) begin
            cnt_q <= cnt_q - CW'(1);
            lo_q  <= lo_n;
            hi_q  <= hi_n;
            busy  <= !last;
            last  <= (cnt_q == CW'(2));
        end
    end

    // One step of shift or shift-add
    always_comb begin
        lo_n    = lo_q;
        hi_n    = hi_q;
        madd    = '0;
        carry_c = 1'b0;
        case (op_q)
            OP_LSL: begin
                lo_n    = {lo_q[MSB-1:0], 1'b0};
                carry_c = lo_q[MSB];
            end
            OP_LSR: begin
                lo_n    = {1'b0, lo_q[MSB:1]};
                carry_c = lo_q[0];
            end
            OP_ASR: begin
                lo_n    = {lo_q[MSB], lo_q[MSB:1]};
                carry_c = lo_q[0];
            end
            OP_MUL: begin
                madd    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : (WIDTH+1)'(0));
                hi_n    = madd[WIDTH:1];
                lo_n    = {madd[0], lo_q[MSB:1]};
                carry_c = |madd[WIDTH:1];
            end
            default: ;
        endcase
    end

    assign res_c = lo_n;

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with registered result and {Z,N,C,V} flags.
// Single-cycle ops complete in one cycle; shifts and MUL iterate on alu_iter_unit.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : alu_seq_if slave (start/opcode/op1/op2 in, ready/done/result/flags out)
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic     clock,
    input  logic     reset,
    alu_seq_if.slave bus
);

    localparam int unsigned MSB  = WIDTH - 1;
    localparam int unsigned HALF = WIDTH / 2;

    alu_state_t         state_q, state_d;
    logic               accept_c, go_iter_c;
    logic               it_load_c, sc_commit_c, it_commit_c;
    logic               it_busy, it_last, it_carry;
    logic [WIDTH-1:0]   it_res;
    logic [FLAGS_W-1:0] it_flags;

    logic               ready_q, done_q;
    logic [WIDTH-1:0]   result_q;
    logic [FLAGS_W-1:0] flags_q;

    logic [WIDTH-1:0]   arith_x, arith_y, sc_val;
    logic               arith_cin, arith_v;
    logic [WIDTH:0]     arith_sum;
    logic               sc_wr, upd_zn, upd_cv;
    logic [FLAGS_W-1:0] sc_flags;

    assign accept_c  = bus.start && (state_q == ST_IDLE);
    // A shift by zero finishes on the single-cycle path
    assign go_iter_c = accept_c && is_iterative(bus.opcode)
                       && ((bus.opcode == OP_MUL) || (bus.op2[SHW-1:0] != '0));

    alu_iter_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
        .clock   (clock),
        .reset   (reset),
        .load    (it_load_c),
        .op      (bus.opcode),
        .a       (bus.op1),
        .b       (bus.op2),
        .busy    (it_busy),
        .last    (it_last),
        .res_c   (it_res),
        .carry_c (it_carry)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go_iter_c) state_d = (bus.opcode == OP_MUL) ? ST_MUL : ST_SHIFT;
            ST_SHIFT,
            ST_MUL:   if (it_busy && it_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM controls
    always_comb begin
        it_load_c   = 1'b0;
        sc_commit_c = 1'b0;
        it_commit_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                it_load_c   = go_iter_c;
                sc_commit_c = accept_c && !go_iter_c;
            end
            ST_SHIFT,
            ST_MUL:   it_commit_c = it_busy && it_last;
            default: ;
        endcase
    end

    // Single-cycle path. Subtraction feeds ~B into the adder, so one overflow
    // rule (same input signs, result sign differs) covers add, sub and NEG.
    always_comb begin
        arith_x   = bus.op1;
        arith_y   = bus.op2;
        arith_cin = 1'b0;
        case (bus.opcode)
            OP_ADC:         arith_cin = flags_q[FLAG_C];
            OP_SUB, OP_CMP: begin arith_y = ~bus.op2; arith_cin = 1'b1; end
            OP_SUC:         begin arith_y = ~bus.op2; arith_cin = flags_q[FLAG_C]; end
            OP_NEG:         begin arith_x = '0; arith_y = ~bus.op1; arith_cin = 1'b1; end
            default: ;
        endcase
        arith_sum = {1'b0, arith_x} + {1'b0, arith_y} + (WIDTH+1)'(arith_cin);
        arith_v   = (arith_x[MSB] == arith_y[MSB]) && (arith_sum[MSB] != arith_x[MSB]);

        sc_val = result_q;
        sc_wr  = 1'b0;
        upd_zn = 1'b0;
        upd_cv = 1'b0;
        case (bus.opcode)
            OP_ADD, OP_ADC, OP_SUB, OP_SUC, OP_NEG: begin
                sc_val = arith_sum[MSB:0]; sc_wr = 1'b1; upd_zn = 1'b1; upd_cv = 1'b1;
            end
            OP_CMP: begin
                sc_val = arith_sum[MSB:0]; upd_zn = 1'b1; upd_cv = 1'b1;
            end
            OP_AND:  begin sc_val = bus.op1 & bus.op2;    sc_wr = 1'b1; upd_zn = 1'b1; end
            OP_OR:   begin sc_val = bus.op1 | bus.op2;    sc_wr = 1'b1; upd_zn = 1'b1; end
            OP_XOR:  begin sc_val = bus.op1 ^ bus.op2;    sc_wr = 1'b1; upd_zn = 1'b1; end
            OP_NOT:  begin sc_val = ~bus.op1;             sc_wr = 1'b1; upd_zn = 1'b1; end
            OP_NAND: begin sc_val = ~(bus.op1 & bus.op2); sc_wr = 1'b1; upd_zn = 1'b1; end
            OP_NOR:  begin sc_val = ~(bus.op1 | bus.op2); sc_wr = 1'b1; upd_zn = 1'b1; end
            OP_LSL, OP_LSR, OP_ASR: begin
                sc_val = bus.op1; sc_wr = 1'b1; upd_zn = 1'b1;
            end
            OP_LUI: begin sc_val = {bus.op2[HALF-1:0], bus.op1[HALF-1:0]}; sc_wr = 1'b1; end
            OP_LLI: begin sc_val = {bus.op1[MSB:HALF], bus.op2[HALF-1:0]}; sc_wr = 1'b1; end
            default: ;
        endcase

        sc_flags = flags_q;
        if (upd_zn) begin
            sc_flags[FLAG_Z] = (sc_val == '0);
            sc_flags[FLAG_N] = sc_val[MSB];
        end
        if (upd_cv) begin
            sc_flags[FLAG_C] = arith_sum[WIDTH];
            sc_flags[FLAG_V] = arith_v;
        end
    end

    // Iterative completion: Z/N on final value, C from the unit, V kept
    always_comb begin
        it_flags         = flags_q;
        it_flags[FLAG_Z] = (it_res == '0);
        it_flags[FLAG_N] = it_res[MSB];
        it_flags[FLAG_C] = it_carry;
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            ready_q <= (state_d == ST_IDLE);
            done_q  <= sc_commit_c || it_commit_c;
            if (sc_commit_c) begin
                if (sc_wr) result_q <= sc_val;
                flags_q <= sc_flags;
            end else if (it_commit_c) begin
                result_q <= it_res;
                flags_q  <= it_flags;
            end
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] m_result = '0;
    logic [3:0]   m_flags  = '0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ovf(input int x);
        return (x > 32767) || (x < -32768);
    endfunction

    // Reference: expected result, flags and Done cycle from plain arithmetic
    task automatic model(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [3:0] f, output int lat);
        int              sa, sb, bw, n;
        logic            zn, c;
        logic [W-1:0]    v;
        longint unsigned p;
        r   = m_result;
        f   = m_flags;
        lat = 1;
        zn  = 1'b0;
        v   = m_result;
        c   = m_flags[FLAG_C];
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        n   = int'(b[3:0]);
        bw  = c ? 0 : 1;
        case (op)
            OP_ADD: begin v = a + b; f[FLAG_C] = (int'(a) + int'(b)) > 65535;
                          f[FLAG_V] = ovf(sa + sb); zn = 1; r = v; end
            OP_ADC: begin v = W'(int'(a) + int'(b) + int'(c));
                          f[FLAG_C] = (int'(a) + int'(b) + int'(c)) > 65535;
                          f[FLAG_V] = ovf(sa + sb + int'(c)); zn = 1; r = v; end
            OP_SUB, OP_CMP: begin v = a - b; f[FLAG_C] = (a >= b);
                          f[FLAG_V] = ovf(sa - sb); zn = 1; if (op == OP_SUB) r = v; end
            OP_SUC: begin v = W'(int'(a) - int'(b) - bw); f[FLAG_C] = int'(a) >= int'(b) + bw;
                          f[FLAG_V] = ovf(sa - sb - bw); zn = 1; r = v; end
            OP_NEG: begin v = W'(0 - int'(a)); f[FLAG_C] = (a == 0);
                          f[FLAG_V] = ovf(-sa); zn = 1; r = v; end
            OP_AND:  begin v = a & b;    zn = 1; r = v; end
            OP_OR:   begin v = a | b;    zn = 1; r = v; end
            OP_XOR:  begin v = a ^ b;    zn = 1; r = v; end
            OP_NOT:  begin v = ~a;       zn = 1; r = v; end
            OP_NAND: begin v = ~(a & b); zn = 1; r = v; end
            OP_NOR:  begin v = ~(a | b); zn = 1; r = v; end
            OP_LSL, OP_LSR, OP_ASR: begin
                zn = 1;
                if (n == 0) v = a;
                else begin
                    lat = n + 1;
                    if (op == OP_LSL) begin v = a << n; f[FLAG_C] = a[W-n]; end
                    else if (op == OP_LSR) begin v = a >> n; f[FLAG_C] = a[n-1]; end
                    else begin v = W'($signed(a) >>> n); f[FLAG_C] = a[n-1]; end
                end
                r = v;
            end
            OP_MUL: begin
                p = longint'(a) * longint'(b);
                v = p[15:0]; f[FLAG_C] = (p >> 16) != 0; zn = 1; lat = W + 1; r = v;
            end
            OP_LUI: r = {b[7:0], a[7:0]};
            OP_LLI: r = {a[15:8], b[7:0]};
            default: ;
        endcase
        if (zn) begin
            f[FLAG_Z] = (v == 0);
            f[FLAG_N] = v[W-1];
        end
    endtask

    // Issue one op at the current cycle; optional ignored Start pulse in cycle noise_cyc
    task automatic do_op(input string tag, input alu_op_t op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int noise_cyc);
        logic [W-1:0] er;
        logic [3:0]   ef;
        int           lat, cyc, busy_cnt;
        model(op, a, b, er, ef, lat);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.op1    = a;
        bus.op2    = b;
        @(posedge clock); #1;
        bus.start = 1'b0;
        cyc       = 1;
        busy_cnt  = 0;
        while (!bus.done && cyc < 64) begin
            if (!bus.ready) busy_cnt++;
            if (cyc == noise_cyc && cyc < lat) begin
                bus.start  = 1'b1;
                bus.opcode = OP_ADD;
                bus.op1    = W'($urandom);
                bus.op2    = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock); #1;
            bus.start = 1'b0;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_res"}, 32'(bus.result), 32'(er));
        check({tag, "_flags"}, 32'(bus.flags), 32'(ef));
        check({tag, "_busy"}, 32'(busy_cnt), 32'(lat - 1));
        m_result = er;
        m_flags  = ef;
    endtask

    initial begin
        int done_cnt;
        logic [4:0] raw;
        alu_op_t rop;
        bus.start  = 1'b0;
        bus.opcode = OP_ADD;
        bus.op1    = '0;
        bus.op2    = '0;

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_result", 32'(bus.result), 32'h0);
        check("rst_flags", 32'(bus.flags), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h1);
        check("rst_done", 32'(bus.done), 32'h0);

        // Reset in the middle of a MUL: op abandoned, no Done
        bus.start = 1'b1; bus.opcode = OP_MUL; bus.op1 = 16'd300; bus.op2 = 16'd300;
        @(posedge clock); #1 bus.start = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        done_cnt = 0;
        repeat (20) begin
            if (bus.done) done_cnt++;
            @(posedge clock); #1;
        end
        check("midrst_done", 32'(done_cnt), 32'h0);
        check("midrst_result", 32'(bus.result), 32'h0);
        check("midrst_flags", 32'(bus.flags), 32'h0);
        check("midrst_ready", 32'(bus.ready), 32'h1);
        m_result = '0;
        m_flags  = '0;

        do_op("add11", OP_ADD, 16'h0001, 16'h0001, 0);
        check("add11_lit", 32'(bus.result), 32'h0002);
        do_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 0);
        check("add_ovf_lit", {16'(bus.result), 12'h0, bus.flags}, {16'h8000, 12'h0, 4'b0101});
        do_op("sub_eq", OP_SUB, 16'h0005, 16'h0005, 0);
        check("sub_eq_lit", {16'(bus.result), 12'h0, bus.flags}, {16'h0000, 12'h0, 4'b1010});
        do_op("add_c", OP_ADD, 16'hFFFF, 16'h0001, 0);
        do_op("adc", OP_ADC, 16'h0000, 16'h0000, 0);
        check("adc_lit", {16'(bus.result), 12'h0, bus.flags}, {16'h0001, 12'h0, 4'b0000});
        do_op("and", OP_AND, 16'hF0F0, 16'h0F0F, 0);
        do_op("lsr4", OP_LSR, 16'h8001, 16'h0004, 0);
        check("lsr4_lit", 32'(bus.result), 32'h0800);
        do_op("asr15", OP_ASR, 16'h8000, 16'h000F, 0);
        check("asr15_lit", 32'(bus.result), 32'hFFFF);
        do_op("mul300", OP_MUL, 16'd300, 16'd300, 3);
        check("mul300_lit", {16'(bus.result), 12'h0, bus.flags}, {16'h5F90, 12'h0, 4'b0010});
        do_op("lui", OP_LUI, 16'h1234, 16'h00AB, 0);
        check("lui_lit", 32'(bus.result), 32'hAB34);
        do_op("cmp", OP_CMP, 16'h0003, 16'h0005, 0);
        check("cmp_lit", {16'(bus.result), 12'h0, bus.flags}, {16'hAB34, 12'h0, 4'b0100});
        do_op("shift0", OP_LSL, 16'hA5A5, 16'h0010, 0);

        // Random ops back to back, including undefined opcodes and ignored Starts
        for (int i = 0; i < 300; i++) begin
            raw = 5'($urandom_range(0, 20));
            rop = alu_op_t'(raw);
            do_op("rnd", rop, W'($urandom), W'($urandom), int'($urandom_range(1, 16)));
        end

        @(posedge clock); #1;
        check("done_pulse", 32'(bus.done), 32'h0);
        check("idle_ready", 32'(bus.ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
